// File: rtl/pkt_frame_fifo.sv
// Single-frame word FIFO between the register/SPI side and the packet datapath.
// Programmable frame length, sticky overflow/underflow, optional edge-detected strobes.
module pkt_frame_fifo #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 128,
    parameter int                LEN_W     = $clog2(DEPTH) + 1,
    parameter bit                EDGE_MODE = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_VAL  = 'h1F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    input  logic              len_wr_en,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              len_rd_en,
    output logic [LEN_W-1:0]  len_out,
    input  logic              clr_err,
    output logic [LEN_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              frame_full,
    output logic              read_complete,
    output logic              overflow,
    output logic              underflow
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]       sync_wr_q, sync_rd_q;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic wr_ev, rd_ev, wr_ok, rd_ok;

    assign count         = wr_ptr_q - rd_ptr_q;
    assign empty         = (count == '0);
    assign full          = (count == DEPTH_L);
    assign frame_full    = (wr_cnt_q >= length_q);
    assign read_complete = (rd_cnt_q >= length_q);
    assign overflow      = ovf_q;
    assign underflow     = udf_q;
    assign len_out       = len_rd_en ? length_q : '0;

    // Edge mode: write on the strobe's rise, read on its fall.
    always_comb begin
        if (EDGE_MODE) begin
            wr_ev = (sync_wr_q == 2'b01);
            rd_ev = (sync_rd_q == 2'b10);
        end else begin
            wr_ev = wr_en;
            rd_ev = rd_en;
        end
    end

    assign wr_ok = wr_ev && !full && !frame_full && !len_wr_en;
    assign rd_ok = rd_ev && !empty && !len_wr_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q + LEN_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + LEN_W'(rd_ok);
        wr_cnt_d = wr_cnt_q + LEN_W'(wr_ok);
        rd_cnt_d = rd_cnt_q + LEN_W'(rd_ok);
        length_d = length_q;
        ovf_d    = ovf_q && !clr_err;
        udf_d    = udf_q && !clr_err;
        if (wr_ev && !wr_ok) ovf_d = 1'b1;
        if (rd_ev && !rd_ok) udf_d = 1'b1;
        if (len_wr_en) begin
            length_d = (len_in > DEPTH_L) ? DEPTH_L : len_in;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_wr_q <= '0;
            sync_rd_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            length_q  <= DEPTH_L;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            sync_wr_q <= {sync_wr_q[0], wr_en};
            sync_rd_q <= {sync_rd_q[0], rd_en};
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            length_q  <= length_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= data_in;
    end

    always_comb begin
        data_out = IDLE_VAL;
        if (!empty && (!EDGE_MODE || rd_en)) data_out = mem[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: tb/tb_pkt_frame_fifo.sv
// Bench for pkt_frame_fifo: one edge-mode and one pulse-mode instance, DEPTH=8.
// Vector table, hand sequences and random traffic against a queue model.
module tb_pkt_frame_fifo;

    localparam int          DW   = 8;
    localparam int          DP   = 8;
    localparam int          LW   = 4;
    localparam logic [7:0]  IDLE = 8'h1F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // pulse-mode instance
    logic          p_wr = 0, p_rd = 0, p_lw = 0, p_clr = 0, p_lrd = 0;
    logic [LW-1:0] p_len = '0;
    logic [DW-1:0] p_din = '0;
    logic [DW-1:0] p_dout;
    logic [LW-1:0] p_lo, p_cnt;
    logic          p_empty, p_full, p_ff, p_rc, p_ovf, p_udf;

    // edge-mode instance
    logic          e_wr = 0, e_rd = 0, e_lw = 0, e_clr = 0, e_lrd = 0;
    logic [LW-1:0] e_len = '0;
    logic [DW-1:0] e_din = '0;
    logic [DW-1:0] e_dout;
    logic [LW-1:0] e_lo, e_cnt;
    logic          e_empty, e_full, e_ff, e_rc, e_ovf, e_udf;

    pkt_frame_fifo #(.DATA_W(DW), .DEPTH(DP), .LEN_W(LW), .EDGE_MODE(1'b0), .IDLE_VAL(IDLE)) u_pulse (
        .clk(clk), .reset(reset), .wr_en(p_wr), .data_in(p_din), .rd_en(p_rd),
        .data_out(p_dout), .len_wr_en(p_lw), .len_in(p_len), .len_rd_en(p_lrd),
        .len_out(p_lo), .clr_err(p_clr), .count(p_cnt), .empty(p_empty),
        .full(p_full), .frame_full(p_ff), .read_complete(p_rc),
        .overflow(p_ovf), .underflow(p_udf)
    );

    pkt_frame_fifo #(.DATA_W(DW), .DEPTH(DP), .LEN_W(LW), .EDGE_MODE(1'b1), .IDLE_VAL(IDLE)) u_edge (
        .clk(clk), .reset(reset), .wr_en(e_wr), .data_in(e_din), .rd_en(e_rd),
        .data_out(e_dout), .len_wr_en(e_lw), .len_in(e_len), .len_rd_en(e_lrd),
        .len_out(e_lo), .clr_err(e_clr), .count(e_cnt), .empty(e_empty),
        .full(e_full), .frame_full(e_ff), .read_complete(e_rc),
        .overflow(e_ovf), .underflow(e_udf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue plus frame counters.
    logic [7:0] mq[$];
    int m_len, m_wc, m_rc;
    bit m_ovf, m_udf;

    function automatic void m_reset();
        mq.delete();
        m_len = DP; m_wc = 0; m_rc = 0; m_ovf = 0; m_udf = 0;
    endfunction

    function automatic void m_step(bit wr, bit rd, bit lw, bit clr, int len, logic [7:0] din);
        bit wa, ra;
        if (lw) begin
            m_len = (len > DP) ? DP : len;
            mq.delete();
            m_wc = 0; m_rc = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        wa = wr && (mq.size() < DP) && (m_wc < m_len);
        ra = rd && (mq.size() > 0);
        if (clr) begin m_ovf = 0; m_udf = 0; end
        if (wr && !wa) m_ovf = 1;
        if (rd && !ra) m_udf = 1;
        if (ra) begin void'(mq.pop_front()); m_rc++; end
        if (wa) begin mq.push_back(din); m_wc++; end
    endfunction

    task automatic cmp_model(input string t);
        chk({t, " count"}, p_cnt, mq.size());
        chk({t, " empty"}, p_empty, mq.size() == 0);
        chk({t, " full"}, p_full, mq.size() == DP);
        chk({t, " frame_full"}, p_ff, m_wc >= m_len);
        chk({t, " read_complete"}, p_rc, m_rc >= m_len);
        chk({t, " overflow"}, p_ovf, m_ovf);
        chk({t, " underflow"}, p_udf, m_udf);
        chk({t, " data_out"}, p_dout, (mq.size() > 0) ? mq[0] : IDLE);
        chk({t, " len_out"}, p_lo, p_lrd ? m_len : 0);
    endtask

    task automatic pstep(input bit wr, input bit rd, input bit lw, input bit clr,
                         input bit lrd, input int len, input logic [7:0] din);
        @(negedge clk);
        p_wr = wr; p_rd = rd; p_lw = lw; p_clr = clr; p_lrd = lrd;
        p_len = LW'(len); p_din = din;
        @(posedge clk);
        m_step(wr, rd, lw, clr, int'(p_len), din);
        #1;
    endtask

    typedef struct {
        bit         wr, rd, lw, clr, lrd;
        int         len;
        logic [7:0] din;
        int         cnt;
        bit         full, ff, rc, ovf, udf;
        logic [7:0] dout;
        int         lo;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit wr, bit rd, bit lw, bit clr, bit lrd, int len, int din,
                                int cnt, bit full, bit ff, bit rc, bit ovf, bit udf,
                                int dout, int lo);
        vec_t v;
        v.wr = wr; v.rd = rd; v.lw = lw; v.clr = clr; v.lrd = lrd;
        v.len = len; v.din = 8'(din);
        v.cnt = cnt; v.full = full; v.ff = ff; v.rc = rc;
        v.ovf = ovf; v.udf = udf; v.dout = 8'(dout); v.lo = lo;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // wr rd lw clr lrd len din | cnt full ff rc ovf udf dout lo
        tv.push_back(mk(0,0,1,0,0, 5,0,      0,0,0,0,0,0,'h1F,0));
        for (int i = 1; i <= 5; i++)
            tv.push_back(mk(1,0,0,0,0, 0,'h10+i-1, i,0,(i==5),0,0,0,'h10,0));
        tv.push_back(mk(1,0,0,0,0, 0,'h15,   5,0,1,0,1,0,'h10,0));
        tv.push_back(mk(0,0,0,1,1, 0,0,      5,0,1,0,0,0,'h10,5));
        tv.push_back(mk(0,0,1,0,0, 8,0,      0,0,0,0,0,0,'h1F,0));
        tv.push_back(mk(1,1,0,0,0, 0,'h20,   1,0,0,0,0,1,'h20,0));
        tv.push_back(mk(0,0,0,1,0, 0,0,      1,0,0,0,0,0,'h20,0));
        for (int i = 1; i <= 7; i++)
            tv.push_back(mk(1,0,0,0,0, 0,'h20+i, 1+i,(i==7),(i==7),0,0,0,'h20,0));
        tv.push_back(mk(1,1,0,0,0, 0,'h28,   7,0,1,0,1,0,'h21,0));
        tv.push_back(mk(0,0,1,0,1, 11,0,     0,0,0,0,0,0,'h1F,8));
        tv.push_back(mk(0,0,1,0,0, 0,0,      0,0,1,1,0,0,'h1F,0));
        tv.push_back(mk(1,0,0,0,0, 0,'h30,   0,0,1,1,1,0,'h1F,0));
        tv.push_back(mk(1,0,1,0,0, 8,'h31,   0,0,0,0,0,0,'h1F,0));
        tv.push_back(mk(0,1,0,0,0, 0,0,      0,0,0,0,0,1,'h1F,0));
        tv.push_back(mk(0,0,0,1,0, 0,0,      0,0,0,0,0,0,'h1F,0));

        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst count", p_cnt, 0);
        chk("rst empty", p_empty, 1);
        chk("rst full", p_full, 0);
        chk("rst frame_full", p_ff, 0);
        chk("rst read_complete", p_rc, 0);
        chk("rst ovf/udf", {p_ovf, p_udf}, 0);
        chk("rst data_out", p_dout, IDLE);
        chk("rst len_out", p_lo, 0);
        chk("rst edge data_out", e_dout, IDLE);

        // Edge mode: three writes, then reads keyed on rd_en falls.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e_din = 8'hA1 + 8'(k);
            e_wr = 1'b1;
            repeat (4) @(negedge clk);
            e_wr = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("edge count3", e_cnt, 3);
        chk("edge gated idle", e_dout, IDLE);
        e_rd = 1'b1;
        #1;
        chk("edge head A1", e_dout, 8'hA1);
        repeat (2) @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            e_rd = 1'b0;
            @(posedge clk); #1;
            chk("edge read not yet", e_cnt, 4 - k);
            @(posedge clk); #1;
            chk("edge read count", e_cnt, 3 - k);
            e_rd = 1'b1;
            #1;
            chk("edge head", e_dout, (k < 3) ? 8'hA1 + 8'(k) : IDLE);
            repeat (2) @(negedge clk);
        end
        chk("edge empty", e_empty, 1);
        chk("edge errors", {e_ovf, e_udf}, 0);
        e_rd = 1'b0;

        // Pulse-mode vector table.
        foreach (tv[i]) begin
            pstep(tv[i].wr, tv[i].rd, tv[i].lw, tv[i].clr, tv[i].lrd, tv[i].len, tv[i].din);
            chk($sformatf("vec%0d count", i), p_cnt, tv[i].cnt);
            chk($sformatf("vec%0d full", i), p_full, tv[i].full);
            chk($sformatf("vec%0d frame_full", i), p_ff, tv[i].ff);
            chk($sformatf("vec%0d read_complete", i), p_rc, tv[i].rc);
            chk($sformatf("vec%0d overflow", i), p_ovf, tv[i].ovf);
            chk($sformatf("vec%0d underflow", i), p_udf, tv[i].udf);
            chk($sformatf("vec%0d data_out", i), p_dout, tv[i].dout);
            chk($sformatf("vec%0d len_out", i), p_lo, tv[i].lo);
        end

        // Fill to full, then alternate reads and writes.
        pstep(0,0,1,0,0, 8,0);
        for (int k = 0; k < 8; k++) pstep(1,0,0,0,0, 0, 8'h40 + 8'(k));
        chk("wrap fill full", p_full, 1);
        chk("wrap fill count", p_cnt, 8);
        for (int k = 0; k < 20; k++) begin
            pstep(k[0], !k[0], 0,0,0, 0, 8'h48 + 8'(k));
            cmp_model($sformatf("wrap%0d", k));
        end

        // Random traffic against the model.
        pstep(0,0,1,0,0, 8,0);
        for (int n = 0; n < 600; n++) begin
            bit lw;
            lw = ($urandom_range(0, 39) == 0);
            pstep($urandom_range(0,1), $urandom_range(0,1), lw,
                  ($urandom_range(0,9) == 0), $urandom_range(0,1),
                  lw ? $urandom_range(0,15) : ((n % 50 == 0) ? 8 : 0),
                  8'($urandom));
            cmp_model($sformatf("rnd%0d", n));
            if (n % 50 == 49) begin
                pstep(0,0,1,0,0, $urandom_range(4,15), 0);
                cmp_model($sformatf("rld%0d", n));
            end
        end

        // Asynchronous reset mid-frame.
        pstep(0,0,1,0,0, 6,0);
        for (int k = 0; k < 4; k++) pstep(1,0,0,0,1, 0, 8'h60 + 8'(k));
        chk("ar pre count", p_cnt, 4);
        pstep(0,0,0,0,1, 0,0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar count", p_cnt, 0);
        chk("ar empty", p_empty, 1);
        chk("ar full", p_full, 0);
        chk("ar frame_full", p_ff, 0);
        chk("ar read_complete", p_rc, 0);
        chk("ar ovf/udf", {p_ovf, p_udf}, 0);
        chk("ar data_out", p_dout, IDLE);
        chk("ar length", p_lo, DP);
        #2;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
